// File: rtl/bb_mem_responder_if.sv
// Memory bus between the bb_core request side and the memory responder.
// The core drives action/address/write-data; the responder returns data and status.
interface bb_mem_responder_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_action;
  logic [DATA_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_busy;
  logic                  o_err;

  modport master (
    output i_action, i_addr, i_data,
    input  o_data, o_valid, o_busy, o_err
  );

  modport slave (
    input  i_action, i_addr, i_data,
    output o_data, o_valid, o_busy, o_err
  );
endinterface

// File: rtl/bb_mem_responder.sv
// Single-port word RAM responder with fixed read latency, sticky error flag and
// zero-when-idle read data so the return bus can be OR-combined.
module bb_mem_responder #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  bb_mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t                  state_r, state_nxt;
  logic [3:0]              cnt_r, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   idx_r, idx_nxt;
  logic [DATA_WIDTH-1:0]   data_r, data_nxt;
  logic                    valid_r, valid_nxt;
  logic                    busy_r, busy_nxt;
  logic                    err_r, err_nxt;
  logic [DATA_WIDTH-1:0]   ram [0:DEPTH-1];

  logic [1:0]              code;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    is_read;
  logic                    is_write;
  logic                    unused_bits;

  assign code     = bus.i_action[1:0];
  assign req_idx  = bus.i_addr[ADDR_WIDTH-1:0];
  assign is_read  = (state_r == IDLE) && (code == 2'd1);
  assign is_write = (state_r == IDLE) && (code == 2'd2);
  assign unused_bits = ^{bus.i_action[DATA_WIDTH-1:2], bus.i_addr[DATA_WIDTH-1:ADDR_WIDTH]};

  // RAM storage, deliberately outside reset so contents survive rst
  always_ff @(posedge clk) begin
    if (is_write) begin
      ram[req_idx] <= bus.i_data;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      idx_r   <= idx_nxt;
      data_r  <= data_nxt;
      valid_r <= valid_nxt;
      busy_r  <= busy_nxt;
      err_r   <= err_nxt;
    end
  end

  // Next-state: leaving RD_WAIT when the counter would reach zero on this edge
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    idx_nxt   = idx_r;
    case (state_r)
      IDLE: begin
        if (is_read) begin
          idx_nxt   = req_idx;
          cnt_nxt   = LAT_M1;
          state_nxt = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_r <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = RD_RESP;
        end else begin
          cnt_nxt   = cnt_r - 4'd1;
        end
      end
      RD_RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output values registered at the next edge; LAT=1 reads from the live address
  always_comb begin
    valid_nxt = (state_nxt == RD_RESP);
    busy_nxt  = (state_nxt != IDLE);
    if (state_nxt == RD_RESP) begin
      data_nxt = (state_r == IDLE) ? ram[req_idx] : ram[idx_r];
    end else begin
      data_nxt = '0;
    end
    if ((code == 2'd3) || ((state_r != IDLE) && (code != 2'd0))) begin
      err_nxt = 1'b1;
    end else begin
      err_nxt = err_r;
    end
  end

  assign bus.o_data  = data_r;
  assign bus.o_valid = valid_r;
  assign bus.o_busy  = busy_r;
  assign bus.o_err   = err_r;
endmodule
